// File: rtl/can_bit_timing.sv
// can_bit_timing
//   CAN bit timing unit. Synchronises the raw CAN receive pin, divides the
//   clock into time quanta (tq) and builds each nominal bit as SYNC (1 tq),
//   TSEG1 and TSEG2. It hard-synchronises or resynchronises on
//   recessive-to-dominant edges and emits one sample per bit.
//
//   Parameters:
//     BRP   clocks per tq (1..64)
//     TSEG1 tq in propagation + phase1 segment (2..16)
//     TSEG2 tq in phase2 segment (1..8)
//     SJW   resync jump width in tq (1..4, SJW <= TSEG2)
//
//   Ports:
//     clock        in   system clock
//     reset        in   synchronous, active-high reset
//     can_rx       in   raw asynchronous CAN pin, 1 = recessive
//     hard_sync_en in   next falling edge is a hard sync (bus idle / intermission)
//     rx_bit       out  sampled bit, valid while sample_point = 1
//     sample_point out  one-clock pulse per bit in the last clock of TSEG1
//     tx_point     out  one-clock pulse in the first clock of SYNC
//
//   Optional build macro TRIPLE_SAMPLE_EN: rx_bit is the majority of the
//   synchronised pin over the sample clock and the two clocks before it.
module can_bit_timing #(
    parameter int unsigned BRP   = 2,
    parameter int unsigned TSEG1 = 5,
    parameter int unsigned TSEG2 = 2,
    parameter int unsigned SJW   = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic can_rx,
    input  logic hard_sync_en,
    output logic rx_bit,
    output logic sample_point,
    output logic tx_point
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_TSEG1,
        ST_TSEG2
    } state_t;

    localparam logic [5:0] PRESC_LAST = 6'(BRP - 1);
    localparam logic [4:0] SEG1_NOM   = 5'(TSEG1);
    localparam logic [4:0] SEG2_NOM   = 5'(TSEG2);
    localparam logic [4:0] SJW_IDX    = 5'(SJW);
    localparam logic [2:0] SJW_TQ     = 3'(SJW);

    state_t     state, state_n;
    logic [4:0] tq_idx, tq_idx_n;
    logic [5:0] presc, presc_n;
    logic [2:0] ext, ext_n;
    logic [2:0] shrink, shrink_n;
    logic       resync_done, resync_done_n;
    logic       hs_pending, hs_pending_n;

    logic       sync1;
    logic       rx_sync;
    logic       rx_sync_d;
    logic       rx_bit_q;
    logic       sample_val;

    logic       edge_det;
    logic       hard_sync;
    logic       resync;
    logic       set_done;
    logic       early_end;
    logic       tq_end;
    logic       seg_last;
    logic [2:0] ext_eff;
    logic [2:0] shrink_eff;
    logic [4:0] seg1_len;
    logic [4:0] seg2_len;
    logic [4:0] tq_next;
    logic [4:0] seg2_left;

`ifdef TRIPLE_SAMPLE_EN
    logic rx_sync_d2;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_sync_d2 <= 1'b1;
        end else begin
            rx_sync_d2 <= rx_sync_d;
        end
    end

    assign sample_val = (rx_sync & rx_sync_d) | (rx_sync & rx_sync_d2) | (rx_sync_d & rx_sync_d2);
`else
    assign sample_val = rx_sync;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= 1'b1;
            rx_sync     <= 1'b1;
            rx_sync_d   <= 1'b1;
            rx_bit_q    <= 1'b1;
            state       <= ST_TSEG1;
            tq_idx      <= '0;
            presc       <= '0;
            ext         <= '0;
            shrink      <= '0;
            resync_done <= 1'b0;
            hs_pending  <= 1'b0;
        end else begin
            sync1       <= can_rx;
            rx_sync     <= sync1;
            rx_sync_d   <= rx_sync;
            if (sample_point) begin
                rx_bit_q <= sample_val;
            end
            state       <= state_n;
            tq_idx      <= tq_idx_n;
            presc       <= presc_n;
            ext         <= ext_n;
            shrink      <= shrink_n;
            resync_done <= resync_done_n;
            hs_pending  <= hs_pending_n;
        end
    end

    // Segment lengths are evaluated with the resync of the current clock
    // already applied, so an edge in the would-be sample clock moves the
    // sample point instead of producing a second one later.
    always_comb begin
        edge_det   = rx_sync_d & ~rx_sync & rx_bit_q;
        hard_sync  = edge_det & hard_sync_en;
        resync     = edge_det & ~hard_sync_en & ~resync_done;
        tq_end     = (presc == PRESC_LAST);
        tq_next    = tq_idx + 5'd1;
        seg2_left  = SEG2_NOM - tq_idx;
        ext_eff    = ext;
        shrink_eff = shrink;
        early_end  = 1'b0;
        set_done   = 1'b0;

        if (resync) begin
            if (state == ST_TSEG1) begin
                ext_eff  = (tq_next < SJW_IDX) ? tq_next[2:0] : SJW_TQ;
                set_done = 1'b1;
            end else if (state == ST_TSEG2) begin
                set_done = 1'b1;
                if (seg2_left <= SJW_IDX) begin
                    early_end = 1'b1;
                end else begin
                    shrink_eff = SJW_TQ;
                end
            end
        end

        seg1_len = SEG1_NOM + {2'b00, ext_eff};
        seg2_len = SEG2_NOM - {2'b00, shrink_eff};

        case (state)
            ST_TSEG1: seg_last = (tq_idx == seg1_len - 5'd1);
            ST_TSEG2: seg_last = (tq_idx == seg2_len - 5'd1);
            default:  seg_last = 1'b1;
        endcase

        sample_point = ~reset & (state == ST_TSEG1) & tq_end & seg_last & ~hard_sync;
        tx_point     = ~reset & (state == ST_SYNC) & (presc == '0);
        rx_bit       = sample_point ? sample_val : rx_bit_q;
    end

    always_comb begin
        state_n       = state;
        tq_idx_n      = tq_idx;
        presc_n       = presc;
        ext_n         = ext_eff;
        shrink_n      = shrink_eff;
        resync_done_n = resync_done | set_done;
        hs_pending_n  = hs_pending;

        if (hard_sync) begin
            // Hard sync restarts TSEG1 and blocks resync until its sample.
            state_n       = ST_TSEG1;
            tq_idx_n      = '0;
            presc_n       = '0;
            ext_n         = '0;
            shrink_n      = '0;
            resync_done_n = 1'b1;
            hs_pending_n  = 1'b1;
        end else if (early_end) begin
            // Late edge in TSEG2: the bit ends here and the next one starts
            // directly in TSEG1 without a SYNC segment.
            state_n       = ST_TSEG1;
            tq_idx_n      = '0;
            presc_n       = '0;
            ext_n         = '0;
            shrink_n      = '0;
            resync_done_n = 1'b0;
            hs_pending_n  = 1'b0;
        end else begin
            presc_n = tq_end ? '0 : presc + 6'd1;
            if (sample_point && hs_pending) begin
                resync_done_n = 1'b0;
                hs_pending_n  = 1'b0;
            end
            if (tq_end) begin
                if (seg_last) begin
                    tq_idx_n = '0;
                    case (state)
                        ST_SYNC:  state_n = ST_TSEG1;
                        ST_TSEG1: state_n = ST_TSEG2;
                        default: begin
                            state_n       = ST_SYNC;
                            ext_n         = '0;
                            shrink_n      = '0;
                            resync_done_n = 1'b0;
                            hs_pending_n  = 1'b0;
                        end
                    endcase
                end else begin
                    tq_idx_n = tq_next;
                end
            end
        end
    end

endmodule
